// File: rtl/dht11_pkg.sv
// dht11_pkg: DHT11 timing constants, us-to-cycles conversion, state encoding and frame helpers
// Shared by the sensor emulator and the host FSM so both ends agree on the protocol.
package dht11_pkg;
  localparam int FRAME_BITS        = 40;
  localparam int DHT_START_MIN_US  = 18000;
  localparam int DHT_REPLY_WAIT_US = 30;
  localparam int DHT_RESP_LOW_US   = 80;
  localparam int DHT_RESP_HIGH_US  = 80;
  localparam int DHT_BIT_LOW_US    = 50;
  localparam int DHT_BIT0_HIGH_US  = 26;
  localparam int DHT_BIT1_HIGH_US  = 70;
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_HOST_LOW   = 4'd1,
    ST_REPLY_WAIT = 4'd2,
    ST_RESP_LOW   = 4'd3,
    ST_RESP_HIGH  = 4'd4,
    ST_BIT_LOW    = 4'd5,
    ST_BIT_HIGH   = 4'd6
  } state_t;
  function automatic int us2cyc(int clk_freq, int us);
    return (clk_freq / 1_000_000) * us;
  endfunction
  // Sum of the four payload bytes mod 256, optionally with its LSB flipped.
  function automatic logic [7:0] csum8(logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] d,
                                       logic corrupt);
    return (a + b + c + d) ^ {7'b0, corrupt};
  endfunction
endpackage

// File: rtl/dht11_sensor_emu_if.sv
// dht11_sensor_emu_if: line and payload signals of the DHT11 sensor emulator
//   line_in        sampled single-wire data line (asynchronous)
//   line_drive_low 1 = pull the line low, 0 = release
//   enable         0 = ignore start pulses
//   hum_*/temp_*   payload bytes, corrupt_csum flips the checksum LSB
//   busy           start accepted until frame end
//   start_seen     1-cycle pulse on accepted start
//   frame_sent     1-cycle pulse on final release
interface dht11_sensor_emu_if;
  logic       line_in;
  logic       line_drive_low;
  logic       enable;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] temp_int;
  logic [7:0] temp_dec;
  logic       corrupt_csum;
  logic       busy;
  logic       start_seen;
  logic       frame_sent;
  modport master (
    output line_in, enable, hum_int, hum_dec, temp_int, temp_dec, corrupt_csum,
    input  line_drive_low, busy, start_seen, frame_sent
  );
  modport slave (
    input  line_in, enable, hum_int, hum_dec, temp_int, temp_dec, corrupt_csum,
    output line_drive_low, busy, start_seen, frame_sent
  );
endinterface

// File: rtl/dht11_sensor_emu_sync_2ff.sv
// sync_2ff: two-flop synchroniser for an asynchronous single-bit input
//   clk, reset_n  clock and asynchronous active-low reset
//   d_i           asynchronous input
//   q_o           synchronised output (2-cycle latency), RST_VAL while in reset
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= {2{RST_VAL}};
    else          sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/dht11_sensor_emu.sv
// dht11_sensor_emu: DHT11 responder that answers a host start pulse with the preamble and a 40-bit frame
//   clk, reset_n  clock and asynchronous active-low reset
//   bus           dht11_sensor_emu_if slave: data line, payload bytes, status pulses
module dht11_sensor_emu
  import dht11_pkg::*;
#(
  parameter int CLK_FREQ      = 12_000_000,
  parameter int START_MIN_US  = DHT_START_MIN_US,
  parameter int REPLY_WAIT_US = DHT_REPLY_WAIT_US,
  parameter int RESP_LOW_US   = DHT_RESP_LOW_US,
  parameter int RESP_HIGH_US  = DHT_RESP_HIGH_US,
  parameter int BIT_LOW_US    = DHT_BIT_LOW_US,
  parameter int BIT0_HIGH_US  = DHT_BIT0_HIGH_US,
  parameter int BIT1_HIGH_US  = DHT_BIT1_HIGH_US
) (
  input logic               clk,
  input logic               reset_n,
  dht11_sensor_emu_if.slave bus
);
  localparam int START_MIN = us2cyc(CLK_FREQ, START_MIN_US);
  localparam int CNT_W     = ($clog2(START_MIN + 1) > 18) ? $clog2(START_MIN + 1) : 18;
  localparam int BC_W      = $clog2(FRAME_BITS + 1);
  typedef logic [CNT_W-1:0] cnt_t;
  localparam cnt_t CNT_MAX        = '1;
  localparam cnt_t START_MIN_C    = cnt_t'(START_MIN);
  // Phase end values: a phase of N cycles ends when the counter reaches N-1.
  localparam cnt_t REPLY_LAST     = cnt_t'(us2cyc(CLK_FREQ, REPLY_WAIT_US) - 1);
  localparam cnt_t RESP_LOW_LAST  = cnt_t'(us2cyc(CLK_FREQ, RESP_LOW_US) - 1);
  localparam cnt_t RESP_HIGH_LAST = cnt_t'(us2cyc(CLK_FREQ, RESP_HIGH_US) - 1);
  localparam cnt_t BIT_LOW_LAST   = cnt_t'(us2cyc(CLK_FREQ, BIT_LOW_US) - 1);
  localparam cnt_t BIT0_LAST      = cnt_t'(us2cyc(CLK_FREQ, BIT0_HIGH_US) - 1);
  localparam cnt_t BIT1_LAST      = cnt_t'(us2cyc(CLK_FREQ, BIT1_HIGH_US) - 1);

  state_t                state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                  drive_q, drive_d;
  logic                  busy_q, busy_d;
  logic                  start_q, start_d;
  logic                  sent_q, sent_d;
  logic                  line_s;
  logic                  start_ok;
  logic                  last_bit;

  // Idle line is high, so the synchroniser resets to 1 to avoid a false start.
  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (bus.line_in),
    .q_o     (line_s)
  );

  assign start_ok = cnt_q >= START_MIN_C;
  assign last_bit = bit_cnt_q == BC_W'(FRAME_BITS);
  // Drive follows the next state so the line changes on the same edge as the state.
  assign drive_d  = (state_d == ST_RESP_LOW) || (state_d == ST_BIT_LOW);

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    busy_d    = busy_q;
    start_d   = 1'b0;
    sent_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d   = '0;
        state_d = (bus.enable && !line_s) ? ST_HOST_LOW : ST_IDLE;
      end
      ST_HOST_LOW: if (line_s) begin
        cnt_d   = '0;
        state_d = start_ok ? ST_REPLY_WAIT : ST_IDLE;
        start_d = start_ok;
        busy_d  = start_ok;
        shreg_d = start_ok ? {bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                              csum8(bus.hum_int, bus.hum_dec, bus.temp_int, bus.temp_dec,
                                    bus.corrupt_csum)} : shreg_q;
      end
      ST_REPLY_WAIT: if (cnt_q == REPLY_LAST) begin
        cnt_d   = '0;
        state_d = ST_RESP_LOW;
      end
      ST_RESP_LOW: if (cnt_q == RESP_LOW_LAST) begin
        cnt_d   = '0;
        state_d = ST_RESP_HIGH;
      end
      ST_RESP_HIGH: if (cnt_q == RESP_HIGH_LAST) begin
        cnt_d     = '0;
        bit_cnt_d = '0;
        state_d   = ST_BIT_LOW;
      end
      ST_BIT_LOW: if (cnt_q == BIT_LOW_LAST) begin
        cnt_d   = '0;
        state_d = last_bit ? ST_IDLE : ST_BIT_HIGH;
        sent_d  = last_bit;
        busy_d  = !last_bit;
      end
      ST_BIT_HIGH: if (cnt_q == (shreg_q[FRAME_BITS-1] ? BIT1_LAST : BIT0_LAST)) begin
        cnt_d     = '0;
        shreg_d   = {shreg_q[FRAME_BITS-2:0], 1'b0};
        bit_cnt_d = bit_cnt_q + 1'b1;
        state_d   = ST_BIT_LOW;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      drive_q   <= 1'b0;
      busy_q    <= 1'b0;
      start_q   <= 1'b0;
      sent_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      drive_q   <= drive_d;
      busy_q    <= busy_d;
      start_q   <= start_d;
      sent_q    <= sent_d;
    end

  assign bus.line_drive_low = drive_q;
  assign bus.busy           = busy_q;
  assign bus.start_seen     = start_q;
  assign bus.frame_sent     = sent_q;
endmodule

// File: tb/tb_dht11_sensor_emu.sv
// tb_dht11_sensor_emu: scoreboard bench; the emulator runs at 1 cycle per us with a 100-cycle start minimum
module tb_dht11_sensor_emu;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic host_low = 1'b0;
  always #5 clk = ~clk;

  dht11_sensor_emu_if bus();
  assign bus.line_in = !(host_low || bus.line_drive_low);

  dht11_sensor_emu #(.CLK_FREQ(1_000_000), .START_MIN_US(100)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad = 0;
  logic [39:0] exp_q[$];
  int starts = 0;
  int done_cnt = 0;
  bit drive_seen = 0;
  bit busy_seen = 0;
  bit in_frame = 0;
  bit ended;
  int seg, run;
  logic prev;
  logic [39:0] cur, rx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Segment k of a frame: reply wait, response low/high, then bit low/high pairs, then end low.
  function automatic int exp_len(input int k, input logic [39:0] f);
    if (k == 0) return 30;
    if (k < 3) return 80;
    if (k % 2 == 1) return 50;
    return f[39 - (k - 4) / 2] ? 70 : 26;
  endfunction

  // Monitor: measures every released/low run of the DUT drive and decodes the frame.
  initial forever begin
    @(negedge clk);
    ended = 0;
    if (!reset_n) in_frame = 0;
    else begin
      if (bus.line_drive_low) drive_seen = 1;
      if (bus.busy) busy_seen = 1;
      if (bus.start_seen) begin
        starts++;
        chk("start_busy", bus.busy, 1);
        chk("start_release", bus.line_drive_low, 0);
        chk("start_expected", exp_q.size() != 0, 1);
        cur = (exp_q.size() != 0) ? exp_q.pop_front() : 40'h0;
        in_frame = 1; seg = 0; run = 1; prev = 1'b0; rx = '0;
      end else if (in_frame) begin
        if (bus.line_drive_low === prev) run++;
        else begin
          chk($sformatf("seg%0d_len", seg), run, exp_len(seg, cur));
          if (seg >= 4 && seg % 2 == 0) rx = {rx[38:0], run > 48};
          if (seg == 83) begin
            ended = 1;
            in_frame = 0;
            chk("frame_data", rx, cur);
            chk("end_busy", bus.busy, 0);
            done_cnt++;
          end
          seg++; run = 1; prev = bus.line_drive_low;
        end
      end
      if (bus.frame_sent || ended) chk("frame_sent", bus.frame_sent, ended);
    end
  end

  task automatic host_pulse(input int len);
    @(posedge clk); #1 host_low = 1;
    repeat (len) @(posedge clk);
    #1 host_low = 0;
  endtask

  task automatic set_data(input logic [7:0] h, hd, t, td, input logic cc);
    bus.hum_int = h; bus.hum_dec = hd; bus.temp_int = t; bus.temp_dec = td; bus.corrupt_csum = cc;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 8000 && done_cnt == n; i++) @(posedge clk);
    chk("frame_done", done_cnt > n, 1);
    repeat (10) @(posedge clk);
  endtask

  task automatic frame(input logic [7:0] h, hd, t, td, input logic cc, input logic [7:0] cs,
                       input int len);
    int n;
    n = done_cnt;
    set_data(h, hd, t, td, cc);
    exp_q.push_back({h, hd, t, td, cs});
    host_pulse(len);
    wait_done(n);
  endtask

  task automatic no_start(input int len);
    int s;
    s = starts; drive_seen = 0; busy_seen = 0;
    host_pulse(len);
    repeat (300) @(posedge clk);
    chk($sformatf("no_start_%0d", len), starts - s, 0);
    chk("no_drive", drive_seen, 0);
    chk("no_busy", busy_seen, 0);
  endtask

  initial begin
    int n, s;
    bus.enable = 1;
    set_data(8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drive", bus.line_drive_low, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_start", bus.start_seen, 0);
    chk("rst_sent", bus.frame_sent, 0);
    reset_n = 1;
    repeat (5) @(posedge clk);
    frame(8'h37, 8'h00, 8'h19, 8'h00, 1'b0, 8'h50, 125);
    frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, 8'h14, 101);
    frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 8'h15, 125);
    frame(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b0, 8'hFC, 125);
    no_start(100);
    no_start(50);
    bus.enable = 0;
    no_start(125);
    bus.enable = 1;
    // Reset in the middle of bit 17's low phase.
    set_data(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    exp_q.push_back({8'h37, 8'h00, 8'h19, 8'h00, 8'h50});
    host_pulse(125);
    for (int i = 0; i < 8000 && !(in_frame && seg == 37); i++) @(negedge clk);
    chk("reach_bit17", seg, 37);
    repeat (10) @(posedge clk);
    #2 chk("pre_reset_drive", bus.line_drive_low, 1);
    #1 reset_n = 0;
    #1 chk("reset_drive", bus.line_drive_low, 0);
    chk("reset_busy", bus.busy, 0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1;
    repeat (5) @(posedge clk);
    frame(8'hA5, 8'h5A, 8'h0F, 8'hF0, 1'b0, 8'hFE, 125);
    // Payload change right after acceptance must not reach the frame.
    n = done_cnt; s = starts;
    set_data(8'h37, 8'h00, 8'h19, 8'h00, 1'b0);
    exp_q.push_back({8'h37, 8'h00, 8'h19, 8'h00, 8'h50});
    host_pulse(125);
    for (int i = 0; i < 100 && starts == s; i++) @(negedge clk);
    @(posedge clk); #1 bus.hum_int = 8'h40;
    wait_done(n);
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
